mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: iterative 32-cycle MULT/MULTU/DIV/DIVU
// engine with HI/LO result registers, mthi/mtlo writes and flush support.
// Operands are reduced to magnitudes on entry; sign is restored in FIX.
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } stateType;

  stateType    state;
  stateType    stateNext;

  // Control strobes decoded by the FSM
  logic        loadOp;
  logic        doIter;
  logic        doWrite;
  logic        doMoveHi;
  logic        doMoveLo;

  // Latched operation context
  logic        isDiv;
  logic        negResult;
  logic        negRem;
  logic        divZero;
  logic [31:0] rsRaw;
  logic [31:0] opB;
  logic [63:0] acc;
  logic [4:0]  counter;

  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        doneReg;

  // Operand magnitudes computed from the live inputs, used on load
  logic        signA;
  logic        signB;
  logic [31:0] magA;
  logic [31:0] magB;

  // One iteration of each algorithm
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [64:0] divShift;
  logic [32:0] divUpper;
  logic        divGe;
  logic [31:0] divDiff;
  logic [63:0] divNext;

  // Sign-corrected results presented in FIX
  logic [63:0] prodFix;
  logic [31:0] quotFix;
  logic [31:0] remFix;
  logic [31:0] fixHi;
  logic [31:0] fixLo;

  assign busy = (state != IDLE);
  assign done = doneReg;
  assign hi   = hiReg;
  assign lo   = loReg;

  // Magnitude extraction; 0x80000000 negates to itself, which is the
  // correct unsigned magnitude.
  always_comb begin
    signA = ~op[0] & rs_val[31];
    signB = ~op[0] & rt_val[31];
    magA  = signA ? (~rs_val + 32'd1) : rs_val;
    magB  = signB ? (~rt_val + 32'd1) : rt_val;
  end

  // Iteration datapath: shift-add multiply and restoring divide
  always_comb begin
    mulSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opB} : 33'd0);
    mulNext  = {mulSum, acc[31:1]};
    divShift = {acc, 1'b0};
    divUpper = divShift[64:32];
    divGe    = (divUpper >= {1'b0, opB});
    // The true difference is below the divisor, so 32 bits hold it exactly
    divDiff  = divUpper[31:0] - opB;
    divNext  = divGe ? {divDiff, divShift[31:1], 1'b1} : divShift[63:0];
  end

  // Result selection with sign correction and divide-by-zero override
  always_comb begin
    prodFix = negResult ? (~acc + 64'd1) : acc;
    quotFix = negResult ? (~acc[31:0] + 32'd1) : acc[31:0];
    remFix  = negRem ? (~acc[63:32] + 32'd1) : acc[63:32];
    if (!isDiv) begin
      fixHi = prodFix[63:32];
      fixLo = prodFix[31:0];
    end else if (divZero) begin
      fixHi = rsRaw;
      fixLo = 32'hFFFF_FFFF;
    end else begin
      fixHi = remFix;
      fixLo = quotFix;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    stateNext = state;
    loadOp    = 1'b0;
    doIter    = 1'b0;
    doWrite   = 1'b0;
    doMoveHi  = 1'b0;
    doMoveLo  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          loadOp    = 1'b1;
          stateNext = CALC;
        end else begin
          doMoveHi = mthi;
          doMoveLo = mtlo;
        end
      end
      CALC: begin
        if (flush) begin
          stateNext = IDLE;
        end else begin
          doIter = 1'b1;
          if (counter == 5'd31) begin
            stateNext = FIX;
          end
        end
      end
      FIX: begin
        stateNext = IDLE;
        doWrite   = ~flush;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Operation context and working register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isDiv     <= 1'b0;
      negResult <= 1'b0;
      negRem    <= 1'b0;
      divZero   <= 1'b0;
      rsRaw     <= 32'd0;
      opB       <= 32'd0;
      acc       <= 64'd0;
      counter   <= 5'd0;
    end else if (loadOp) begin
      isDiv     <= op[1];
      negResult <= signA ^ signB;
      negRem    <= signA;
      divZero   <= (rt_val == 32'd0);
      rsRaw     <= rs_val;
      // Multiply keeps the multiplier in the low half; divide shifts the
      // dividend up out of the low half.
      opB       <= op[1] ? magB : magA;
      acc       <= {32'd0, op[1] ? magA : magB};
      counter   <= 5'd0;
    end else if (doIter) begin
      acc     <= isDiv ? divNext : mulNext;
      counter <= counter + 5'd1;
    end
  end

  // HI/LO architectural registers and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hiReg   <= 32'd0;
      loReg   <= 32'd0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= doWrite;
      if (doWrite) begin
        hiReg <= fixHi;
        loReg <= fixLo;
      end else begin
        if (doMoveHi) hiReg <= wdata;
        if (doMoveLo) loReg <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal results.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mdu_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .flush  (flush),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, {hi, lo}
  function automatic logic [63:0] mduRef(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (o)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Reference model: an operation is a countdown of 33 cycles followed by
  // a HI/LO write; nothing else is accepted while it runs.
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  logic        mDone = 1'b0;
  int          mRemain = 0;
  logic [63:0] mPend = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mHi     <= 32'd0;
      mLo     <= 32'd0;
      mDone   <= 1'b0;
      mRemain <= 0;
      mPend   <= 64'd0;
    end else begin
      mDone <= 1'b0;
      if (mRemain == 0) begin
        if (start) begin
          mPend   <= mduRef(op, rs_val, rt_val);
          mRemain <= 33;
        end else begin
          if (mthi) mHi <= wdata;
          if (mtlo) mLo <= wdata;
        end
      end else if (flush) begin
        mRemain <= 0;
      end else begin
        mRemain <= mRemain - 1;
        if (mRemain == 1) begin
          mHi   <= mPend[63:32];
          mLo   <= mPend[31:0];
          mDone <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("model_hi", hi, mHi);
    check("model_lo", lo, mLo);
    check("model_busy", {31'd0, busy}, {31'd0, mRemain != 0});
    check("model_done", {31'd0, done}, {31'd0, mDone});
  end

  // Wait for done, counting busy cycles on the way
  task automatic waitDone(output bit got, output int busyCycles);
    got = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busyCycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic expectOp(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit withFlush,
                          input logic [31:0] expHi, input logic [31:0] expLo);
    bit got;
    int busyCycles;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; flush = withFlush;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    waitDone(got, busyCycles);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
    end
    check({name, "_busy"}, busyCycles, 32'd33);
    check({name, "_hi"}, hi, expHi);
    check({name, "_lo"}, lo, expLo);
    $display("txn %s op=%0d rs=%h rt=%h -> hi=%h lo=%h busy=%0d", name, o, a, b, hi, lo, busyCycles);
    @(negedge clk);
    check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit got;
    int busyCycles;
    int doneSeen;
    rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    expectOp("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'h5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    expectOp("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 32'h1, 32'hFFFF_FFFE);
    expectOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    expectOp("divu_zero", OP_DIVU, 32'h64, 32'h0, 1'b0, 32'h64, 32'hFFFF_FFFF);
    expectOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
    expectOp("div_zero_s", OP_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    expectOp("div_negdiv", OP_DIV, 32'h7, 32'hFFFF_FFFE, 1'b0, 32'h1, 32'hFFFF_FFFD);
    expectOp("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0);
    expectOp("multu_flush_idle", OP_MULTU, 32'h6, 32'h7, 1'b1, 32'h0, 32'h2A);

    // mthi in IDLE, then ignored mtlo/start while busy
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    start = 1'b1; op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    mtlo = 1'b1; start = 1'b1; op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mtlo = 1'b0; start = 1'b0;
    waitDone(got, busyCycles);
    check("busy_ignore_done", {31'd0, got}, 32'd1);
    check("busy_ignore_hi", hi, 32'd2);
    check("busy_ignore_lo", lo, 32'd14);
    $display("txn busy_ignore hi=%h lo=%h", hi, lo);

    // Preload HI/LO together, flush mid-CALC
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = OP_MULTU; rs_val = 32'd12345; rt_val = 32'd6789;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc_busy", {31'd0, busy}, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    check("flush_calc_nodone", doneSeen, 32'd0);
    check("flush_calc_hi", hi, 32'hAAAA_AAAA);
    check("flush_calc_lo", lo, 32'hAAAA_AAAA);
    $display("txn flush_calc hi=%h lo=%h", hi, lo);

    // Flush exactly in FIX suppresses the write
    start = 1'b1; op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    check("flush_fix_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fix_busy", {31'd0, busy}, 32'd0);
    check("flush_fix_done", {31'd0, done}, 32'd0);
    check("flush_fix_hi", hi, 32'hAAAA_AAAA);
    check("flush_fix_lo", lo, 32'hAAAA_AAAA);
    $display("txn flush_fix hi=%h lo=%h", hi, lo);

    // Asynchronous reset mid-DIV
    start = 1'b1; op = OP_DIV; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    $display("txn async_reset hi=%h lo=%h busy=%0d", hi, lo, busy);
    @(negedge clk);
    rst = 1'b0;
    expectOp("mult_after_rst", OP_MULT, 32'd3, 32'd4, 1'b0, 32'h0, 32'hC);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
